// File: rtl/activation_unit.sv
// Activation unit: per-lane bias add, optional ReLU and int8 saturation on each systolic-array row,
// buffered in a small FIFO that the SRAM controller drains one packed word at a time.
module activation_unit #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned PSUM_W     = 16,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    bias_load,
    input  logic [LANES*OUT_W-1:0]  bias_in,
    input  logic                    relu_en,
    input  logic                    array_valid,
    input  logic [LANES*PSUM_W-1:0] array_psum,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic [LANES*OUT_W-1:0]  activations,
    output logic                    activated,
    output logic                    fifo_full,
    output logic                    overflow_err,
    output logic                    idle
);

    localparam int unsigned WORD_W = LANES * OUT_W;
    localparam int unsigned SUM_W  = PSUM_W + 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (OUT_W - 1)));

    logic [WORD_W-1:0]        bias_q;
    logic signed [SUM_W-1:0]  sum_c [LANES];
    logic signed [SUM_W-1:0]  s1_sum [LANES];
    logic                     s1_valid;
    logic signed [SUM_W-1:0]  lane_c;
    logic [WORD_W-1:0]        sat_word_c;
    logic [WORD_W-1:0]        s2_word;
    logic                     s2_valid;

    logic [WORD_W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     push_c;
    logic                     pop_c;
    logic                     write_c;
    logic                     drop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Bias register; a row sampled on the load edge still sees the previous bias
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bias_q <= '0;
        end else if (bias_load) begin
            bias_q <= bias_in;
        end
    end

    always_comb begin
        sum_c = '{default: '0};
        for (int i = 0; i < int'(LANES); i++) begin
            sum_c[i] = SUM_W'($signed(array_psum[i*PSUM_W +: PSUM_W]))
                     + SUM_W'($signed(bias_q[i*OUT_W +: OUT_W]));
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= array_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (array_valid) begin
            s1_sum <= sum_c;
        end
    end

    // ReLU then clamp to the signed output range
    always_comb begin
        sat_word_c = '0;
        lane_c     = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_c = s1_sum[i];
            if (relu_en && lane_c[SUM_W-1]) begin
                lane_c = '0;
            end
            if (lane_c > SAT_MAX) begin
                lane_c = SAT_MAX;
            end else if (lane_c < SAT_MIN) begin
                lane_c = SAT_MIN;
            end
            sat_word_c[i*OUT_W +: OUT_W] = lane_c[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            s2_word <= sat_word_c;
        end
    end

    // A pop frees the slot, so a push into a full FIFO is accepted when a pop coincides
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign push_c    = s2_valid;
    assign pop_c     = (count != '0) && out_ready;
    assign write_c   = push_c && (!fifo_full || pop_c);
    assign drop_c    = push_c && fifo_full && !pop_c;
    assign idle      = !s1_valid && !s2_valid && (count == '0);

    always_ff @(posedge clk) begin
        if (write_c) begin
            mem[wr_ptr] <= s2_word;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            activations  <= '0;
            activated    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            activated <= pop_c;
            if (pop_c) begin
                activations <= mem[rd_ptr];
                rd_ptr      <= ptr_inc(rd_ptr);
            end
            if (write_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (write_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_c && !write_c) begin
                count <= count - CNT_W'(1);
            end
            if (drop_c) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// Directed and randomized checks of activation_unit against an arithmetic reference model
// and an in-order scoreboard of expected activation words.
module tb_activation_unit;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         bias_load;
    logic [63:0]  bias_in;
    logic         relu_en;
    logic         array_valid;
    logic [127:0] array_psum;
    logic         out_ready;
    logic         err_clr;
    logic [63:0]  activations;
    logic         activated;
    logic         fifo_full;
    logic         overflow_err;
    logic         idle;

    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [63:0]  bias_m;
    logic [63:0]  exp_q [$];
    logic [63:0]  obs_q [$];
    int           strobe_at [$];

    activation_unit dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bias_load    (bias_load),
        .bias_in      (bias_in),
        .relu_en      (relu_en),
        .array_valid  (array_valid),
        .array_psum   (array_psum),
        .out_ready    (out_ready),
        .err_clr      (err_clr),
        .activations  (activations),
        .activated    (activated),
        .fifo_full    (fifo_full),
        .overflow_err (overflow_err),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every delivered word and when it arrived
    always @(negedge clk) begin
        if (n_rst === 1'b1 && activated === 1'b1) begin
            obs_q.push_back(activations);
            strobe_at.push_back(cyc);
        end
    end

    // Reference: plain integer add, optional clamp at zero, clamp to int8
    function automatic logic [63:0] ref_word(input logic [127:0] psum, input logic [63:0] bias,
                                             input bit relu);
        logic [63:0] w;
        int s;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            s = int'($signed(psum[16*i +: 16])) + int'($signed(bias[8*i +: 8]));
            if (relu && s < 0) s = 0;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            w[8*i +: 8] = 8'(s);
        end
        return w;
    endfunction

    function automatic logic [127:0] rand_psum();
        logic [127:0] p;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(2) == 0) p[16*i +: 16] = 16'($signed(9'($urandom_range(511))) );
            else                        p[16*i +: 16] = 16'($urandom);
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one row for one edge; the model uses the bias in force before this edge
    task automatic send(input logic [127:0] p, input bit keep);
        array_valid = 1'b1;
        array_psum  = p;
        if (keep) exp_q.push_back(ref_word(p, bias_m, relu_en));
        if (bias_load) bias_m = bias_in;
        tick(1);
        array_valid = 1'b0;
        bias_load   = 1'b0;
    endtask

    task automatic score(input string tag);
        while (obs_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_spurious"}, 64'(obs_q.size()), 64'd0);
                obs_q.delete();
            end else begin
                chk(tag, obs_q.pop_front(), exp_q.pop_front());
            end
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (!(idle === 1'b1 && obs_q.size() >= exp_q.size()) && k < 60) begin
            tick(1);
            k++;
        end
        tick(1);
        score(tag);
        chk({tag, "_idle"}, {63'd0, idle}, 64'd1);
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] gap(input int first, input int last);
        if (strobe_at.size() <= last) return 64'hFFFF;
        return 64'(strobe_at[last] - strobe_at[first]);
    endfunction

    initial begin
        int b;
        logic [127:0] p;
        logic [63:0]  newb;

        n_rst = 1'b0; bias_load = 1'b0; bias_in = '0; relu_en = 1'b0;
        array_valid = 1'b0; array_psum = '0; out_ready = 1'b1; err_clr = 1'b0;
        bias_m = '0;
        #2;
        chk("rst_activations", activations, 64'd0);
        chk("rst_activated", {63'd0, activated}, 64'd0);
        chk("rst_fifo_full", {63'd0, fifo_full}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
        chk("rst_idle", {63'd0, idle}, 64'd1);
        tick(2);
        @(negedge clk);
        n_rst = 1'b1;
        tick(1);

        // Plan 1: saturation without ReLU, 3-cycle latency
        p = {16'h0001, 16'h0000, 16'hFF80, 16'h007F, 16'hFF00, 16'h00C8, 16'hFFFB, 16'h0005};
        send(p, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t1_latency_%0d", k), {63'd0, activated}, (k == 3) ? 64'd1 : 64'd0);
            if (k == 3) chk("t1_word", activations, 64'h0100_807F_807F_FB05);
        end
        drain("t1");

        // Plan 2: bias + ReLU, back-to-back rows, positive saturation
        bias_load = 1'b1; bias_in = {8{8'h10}}; bias_m = bias_in;
        tick(1);
        bias_load = 1'b0;
        relu_en = 1'b1;
        b = strobe_at.size();
        send({8{16'hFFF0}}, 1'b1);
        send({8{16'hFFE0}}, 1'b1);
        send({8{16'h0070}}, 1'b1);
        drain("t2");
        chk("t2_back_to_back", gap(b, b + 1), 64'd1);
        chk("t2_sat_word", activations, {8{8'h7F}});
        relu_en = 1'b0;

        // Plan 3: fill with no consumer, overflow drops the fifth row
        out_ready = 1'b0;
        b = strobe_at.size();
        for (int r = 0; r < 4; r++) send(rand_psum(), 1'b1);
        tick(3);
        chk("t3_full", {63'd0, fifo_full}, 64'd1);
        chk("t3_no_strobe", 64'(strobe_at.size() - b), 64'd0);
        send(rand_psum(), 1'b0);
        tick(3);
        chk("t3_overflow", {63'd0, overflow_err}, 64'd1);
        chk("t3_still_full", {63'd0, fifo_full}, 64'd1);
        out_ready = 1'b1;
        tick(6);
        chk("t3_count", 64'(strobe_at.size() - b), 64'd4);
        chk("t3_consecutive", gap(b, b + 3), 64'd3);
        drain("t3");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_err_clr", {63'd0, overflow_err}, 64'd0);

        // Plan 4: push into a full FIFO on the same edge as a pop
        out_ready = 1'b0;
        b = strobe_at.size();
        for (int r = 0; r < 4; r++) send(rand_psum(), 1'b1);
        tick(3);
        chk("t4_full", {63'd0, fifo_full}, 64'd1);
        send(rand_psum(), 1'b1);
        tick(1);
        out_ready = 1'b1;
        tick(8);
        chk("t4_no_overflow", {63'd0, overflow_err}, 64'd0);
        chk("t4_count", 64'(strobe_at.size() - b), 64'd5);
        drain("t4");

        // Plan 5: bias load coincident with a row
        newb = 64'h0102_0304_F0E0_7F80;
        bias_load = 1'b1; bias_in = newb;
        send('0, 1'b1);
        chk("t5_first_pending", exp_q[exp_q.size()-1], {8{8'h10}});
        send('0, 1'b1);
        drain("t5");
        chk("t5_new_bias", activations, newb);

        // Plan 6: reset with rows in flight and in the FIFO
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) send(rand_psum(), 1'b1);
        tick(3);
        send(rand_psum(), 1'b1);
        send(rand_psum(), 1'b1);
        chk("t6_busy", {63'd0, idle}, 64'd0);
        n_rst = 1'b0;
        #1;
        chk("t6_rst_activations", activations, 64'd0);
        chk("t6_rst_activated", {63'd0, activated}, 64'd0);
        chk("t6_rst_fifo_full", {63'd0, fifo_full}, 64'd0);
        chk("t6_rst_overflow", {63'd0, overflow_err}, 64'd0);
        chk("t6_rst_idle", {63'd0, idle}, 64'd1);
        exp_q.delete();
        bias_m = '0;
        out_ready = 1'b1;
        tick(2);
        @(negedge clk);
        n_rst = 1'b1;
        b = strobe_at.size();
        tick(8);
        chk("t6_no_strobe", 64'(strobe_at.size() - b), 64'd0);
        chk("t6_idle", {63'd0, idle}, 64'd1);

        // Randomized traffic, bias reloads and backpressure; never more than four outstanding
        for (int batch = 0; batch < 2; batch++) begin
            relu_en = (batch == 1);
            for (int c = 0; c < 150; c++) begin
                out_ready = 1'($urandom_range(1));
                if ($urandom_range(7) == 0) begin
                    bias_load = 1'b1;
                    bias_in   = {$urandom, $urandom};
                end
                if ((exp_q.size() - obs_q.size()) < 4 && $urandom_range(1) == 1) begin
                    send(rand_psum(), 1'b1);
                end else begin
                    if (bias_load) bias_m = bias_in;
                    tick(1);
                    bias_load = 1'b0;
                end
                if (c % 16 == 15) score($sformatf("rand%0d", batch));
            end
            drain($sformatf("rand%0d_end", batch));
            chk($sformatf("rand%0d_no_overflow", batch), {63'd0, overflow_err}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
